// File: rtl/bcd_stopwatch_pkg.sv
// bcd_stopwatch_pkg: FSM states, seven-segment patterns and BCD helpers for the stopwatch
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Valid BCD values order the same way as their decimal meaning, so a plain compare works
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd_stopwatch_tick_gen.sv
// tick_gen: prescaler producing a one-cycle enable every CLK_HZ/TICK_HZ clocks
module tick_gen #(
  parameter int CLK_HZ  = 1_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = $clog2(DIV);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("tick_gen: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == W'(DIV - 1));

  // Count enabled cycles, restarting after each tick; clr wins over en
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en) cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: two-digit BCD up/down stopwatch with lap freeze and seven-segment outputs
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 1_000_000,
  parameter int TICK_HZ   = 1,
  parameter int MAX_COUNT = 59
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic       Down,
  input  logic       Load,
  input  logic [7:0] LoadVal,
  input  logic       Lap,
  output logic [7:0] Cnt,
  output logic [6:0] High,
  output logic [6:0] Low,
  output logic       Running,
  output logic       Done,
  output logic       Wrap,
  output logic       LapHold
);
  if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max
    $error("bcd_stopwatch: MAX_COUNT must be in 1..99");
  end

  localparam logic [7:0] MAX_BCD = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] disp_q, disp_d;
  logic       down_q, down_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;
  logic       lap_q, lap_d;
  logic       tick, pre_clr, pre_en;
  logic       clr, stp, sta, ld, step, start_idle, lap_take;
  logic [7:0] shown;

  // Commands resolve by priority: only the highest asserted one acts
  assign clr        = Clear;
  assign stp        = !Clear && Stop;
  assign sta        = !Clear && !Stop && Start;
  assign ld         = !Clear && !Stop && !Start && Load;
  assign start_idle = sta && (state_q == IDLE);
  assign step       = (state_q == RUN) && tick && !clr;
  assign lap_take   = !clr && Lap && !lap_q && (state_q == RUN);
  assign pre_clr    = clr || start_idle;
  assign pre_en     = (state_q == RUN);

  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  end

  // FSM next state; a down-count reaching zero outranks a simultaneous Stop
  always_comb begin
    state_d = state_q;
    if (clr) state_d = IDLE;
    else if (step && down_q && cnt_q == 8'h01) state_d = DONE;
    else if (stp && state_q == RUN) state_d = PAUSE;
    else if (start_idle) state_d = (Down && cnt_q == 8'h00) ? DONE : RUN;
    else if (sta && state_q == PAUSE) state_d = RUN;
    else if (ld && state_q == DONE) state_d = IDLE;
  end

  // FSM outputs and display source
  always_comb begin
    Running = (state_q == RUN);
    shown   = lap_q ? disp_q : cnt_q;
    Cnt     = cnt_q;
    High    = seg7(shown[7:4]);
    Low     = seg7(shown[3:0]);
    Done    = done_q;
    Wrap    = wrap_q;
    LapHold = lap_q;
  end

  // Datapath next values: count, direction latch, pulses and lap freeze
  always_comb begin
    cnt_d  = clr ? 8'h00
           : step ? (down_q ? ((cnt_q != 8'h00) ? bcd_dec(cnt_q) : cnt_q)
                            : ((cnt_q == MAX_BCD) ? 8'h00 : bcd_inc(cnt_q)))
           : (ld && state_q != RUN && bcd_ok(LoadVal, MAX_BCD)) ? LoadVal
           : cnt_q;
    down_d = start_idle ? Down : down_q;
    done_d = !clr && ((step && down_q && cnt_q == 8'h01) || (start_idle && Down && cnt_q == 8'h00));
    wrap_d = step && !down_q && (cnt_q == MAX_BCD);
    lap_d  = clr ? 1'b0 : (Lap && lap_q) ? 1'b0 : lap_take ? 1'b1 : lap_q;
    disp_d = lap_take ? cnt_q : disp_q;
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= 8'h00;
      disp_q <= 8'h00;
      down_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      lap_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      down_q <= down_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
      lap_q  <= lap_d;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed self-checking bench for bcd_stopwatch at 10 clocks per tick
module tb_bcd_stopwatch;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       Start = 1'b0, Stop = 1'b0, Clear = 1'b0, Down = 1'b0, Load = 1'b0, Lap = 1'b0;
  logic [7:0] LoadVal = 8'h00;
  logic [7:0] Cnt;
  logic [6:0] High, Low;
  logic       Running, Done, Wrap, LapHold;
  int         checks = 0;
  int         errors = 0;
  int         wraps, dones;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b1110000;

  bcd_stopwatch #(.CLK_HZ(10), .TICK_HZ(1), .MAX_COUNT(59)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Stop(Stop), .Clear(Clear), .Down(Down),
    .Load(Load), .LoadVal(LoadVal), .Lap(Lap), .Cnt(Cnt), .High(High), .Low(Low),
    .Running(Running), .Done(Done), .Wrap(Wrap), .LapHold(LapHold)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    #2;
    chk("rst_cnt", Cnt, 8'h00);
    chk("rst_high", High, S0);
    chk("rst_low", Low, S0);
    chk("rst_run", Running, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_wrap", Wrap, 1'b0);
    chk("rst_lap", LapHold, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    Start = 1'b1; step(); Start = 1'b0;
    chk("up_running", Running, 1'b1);
    chk("up_start_cnt", Cnt, 8'h00);
    wraps = 0;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (Wrap) wraps++;
      if (c == 9) chk("up_no_early_tick", Cnt, 8'h00);
      if (c % 10 == 0) chk($sformatf("up_cnt_%0d", c), Cnt, to_bcd((c / 10) % 60));
      if (c == 590) chk("up_at_max", Cnt, 8'h59);
      if (c == 600) chk("up_wrap_pulse", Wrap, 1'b1);
    end
    step();
    chk("up_wrap_one_cycle", Wrap, 1'b0);
    chk("up_wrap_count", wraps, 1);
    chk("up_still_running", Running, 1'b1);
    Clear = 1'b1; step(); Clear = 1'b0;
    chk("clr_running", Running, 1'b0);
    chk("clr_cnt", Cnt, 8'h00);

    LoadVal = 8'h03; Load = 1'b1; step(); Load = 1'b0;
    chk("dn_load", Cnt, 8'h03);
    Down = 1'b1; Start = 1'b1; step(); Start = 1'b0; Down = 1'b0;
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (Done) dones++;
      if (c == 9) chk("dn_cnt_9", Cnt, 8'h03);
      if (c == 10) chk("dn_cnt_10", Cnt, 8'h02);
      if (c == 20) chk("dn_cnt_20", Cnt, 8'h01);
      if (c == 29) chk("dn_run_29", Running, 1'b1);
    end
    chk("dn_cnt_30", Cnt, 8'h00);
    chk("dn_done_30", Done, 1'b1);
    chk("dn_run_fell", Running, 1'b0);
    step();
    chk("dn_done_one_cycle", Done, 1'b0);
    Down = 1'b1; Start = 1'b1; step(); Start = 1'b0; Down = 1'b0;
    steps(15);
    chk("dn_start_ignored_run", Running, 1'b0);
    chk("dn_start_ignored_done", Done, 1'b0);
    chk("dn_done_count", dones, 1);
    Clear = 1'b1; step(); Clear = 1'b0;

    Down = 1'b1; Start = 1'b1; step(); Start = 1'b0; Down = 1'b0;
    chk("zero_dn_done", Done, 1'b1);
    chk("zero_dn_run", Running, 1'b0);
    step();
    chk("zero_dn_done_clr", Done, 1'b0);
    chk("zero_dn_cnt", Cnt, 8'h00);
    Clear = 1'b1; step(); Clear = 1'b0;

    Start = 1'b1; step(); Start = 1'b0;
    steps(14);
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("pause_cnt", Cnt, 8'h01);
    chk("pause_run", Running, 1'b0);
    steps(50);
    chk("pause_hold", Cnt, 8'h01);
    Start = 1'b1; step(); Start = 1'b0;
    chk("resume_run", Running, 1'b1);
    steps(4);
    chk("resume_4", Cnt, 8'h01);
    step();
    chk("resume_5", Cnt, 8'h02);

    Clear = 1'b1; Stop = 1'b1; Start = 1'b1; step(); Clear = 1'b0; Stop = 1'b0; Start = 1'b0;
    chk("css_run", Running, 1'b0);
    chk("css_cnt", Cnt, 8'h00);
    steps(12);
    chk("css_idle_hold", Cnt, 8'h00);
    LoadVal = 8'h6A; Load = 1'b1; step(); Load = 1'b0;
    chk("load_6a_ignored", Cnt, 8'h00);
    LoadVal = 8'h60; Load = 1'b1; step(); Load = 1'b0;
    chk("load_60_ignored", Cnt, 8'h00);
    LoadVal = 8'h59; Load = 1'b1; step(); Load = 1'b0;
    chk("load_59", Cnt, 8'h59);
    Clear = 1'b1; step(); Clear = 1'b0;

    Start = 1'b1; step(); Start = 1'b0;
    steps(71);
    chk("lap_pre_cnt", Cnt, 8'h07);
    Lap = 1'b1; step(); Lap = 1'b0;
    chk("lap_hold", LapHold, 1'b1);
    chk("lap_high", High, S0);
    chk("lap_low", Low, S7);
    steps(48);
    chk("lap_live_cnt", Cnt, 8'h12);
    chk("lap_frozen_high", High, S0);
    chk("lap_frozen_low", Low, S7);
    Lap = 1'b1; step(); Lap = 1'b0;
    chk("unlap_hold", LapHold, 1'b0);
    chk("unlap_high", High, S1);
    chk("unlap_low", Low, S2);

    steps(99);
    chk("run_cnt_22", Cnt, 8'h22);
    Lap = 1'b1; step(); Lap = 1'b0;
    steps(109);
    chk("run_cnt_33", Cnt, 8'h33);
    chk("lap2_low", Low, S2);
    #3;
    RST_N = 1'b0;
    #1;
    chk("arst_cnt", Cnt, 8'h00);
    chk("arst_run", Running, 1'b0);
    chk("arst_lap", LapHold, 1'b0);
    chk("arst_high", High, S0);
    chk("arst_low", Low, S0);
    chk("arst_done", Done, 1'b0);
    chk("arst_wrap", Wrap, 1'b0);
    steps(3);
    chk("arst_held_cnt", Cnt, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
